pu_recv: RTL

PU_RECV -- requirements
Module: pu_recv

---
 rtl/pu_pkg.sv | 16 +
 rtl/pu_recv.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pu_pkg.sv
// Shared definitions for the processing-unit blocks: receiver FSM states and default widths.
package pu_pkg;

    localparam int unsigned DefDw = 16;
    localparam int unsigned DefAw = 8;
    // Port-number width is fixed by the SEND instruction encoding.
    localparam int unsigned PortW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSize,
        StData,
        StDone
    } pu_recv_state_e;

endpackage

// File: rtl/pu_recv.sv
// Link receiver: accepts a header/size/data frame addressed to PORT and streams the data words
// into data memory starting at the header's base address.
module pu_recv
    import pu_pkg::*;
#(
    parameter logic [PortW-1:0] PORT = 4'h0,
    parameter int unsigned      DW   = DefDw,
    parameter int unsigned      AW   = DefAw
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             rx_valid,
    input  logic [PortW-1:0] rx_port,
    input  logic [DW-1:0]    rx_data,
    output logic             rx_ready,
    output logic             dm_req,
    input  logic             dm_gnt,
    output logic             dm_we,
    output logic [AW-1:0]    dm_addr,
    output logic [DW-1:0]    dm_wd,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    pu_recv_state_e state_q, state_d;
    logic [AW-1:0]  base_q, base_d;
    logic [AW-1:0]  remain_q, remain_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           wrap_q, wrap_d;
    logic [AW:0]    addr_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            base_q   <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
        end
    end

    // Extra top bit exposes the carry used for the wrap flag.
    assign addr_sum = {1'b0, base_q} + {1'b0, cnt_q};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        wrap_d   = wrap_q;
        rx_ready = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wd    = '0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                rx_ready = 1'b1;
                if (rx_valid && rx_port == PORT) begin
                    base_d  = rx_data[AW-1:0];
                    wrap_d  = 1'b0;
                    state_d = StSize;
                end
            end
            StSize: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    remain_d = rx_data[AW-1:0];
                    cnt_d    = '0;
                    state_d  = (rx_data[AW-1:0] == '0) ? StDone : StData;
                end
            end
            StData: begin
                dm_req   = rx_valid;
                rx_ready = dm_gnt;
                dm_we    = rx_valid & dm_gnt;
                dm_addr  = addr_sum[AW-1:0];
                dm_wd    = rx_data;
                if (rx_valid && dm_gnt) begin
                    cnt_d    = cnt_q + AW'(1);
                    remain_d = remain_q - AW'(1);
                    if (addr_sum[AW]) begin
                        wrap_d = 1'b1;
                    end
                    if (remain_q == AW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort discards any update from this cycle; earlier writes stay in memory.
        if (clr) begin
            state_d  = StIdle;
            base_d   = base_q;
            remain_d = remain_q;
            cnt_d    = cnt_q;
            wrap_d   = wrap_q;
            rx_ready = 1'b0;
            dm_we    = 1'b0;
            done     = 1'b0;
        end

        if (!rst_n) begin
            rx_ready = 1'b0;
        end
    end

    assign busy = (state_q != StIdle);
    assign wrap = wrap_q;

endmodule
